// File: rtl/pc_gen_unit.sv
// ---------------------------------------------------------------------------
// pc_gen_unit
//   Fetch-PC generator for the CPU core. Holds the current fetch address and
//   selects the next one from sequential, branch, JALR or return-from-trap
//   sources. It also supports a pipeline stall and a boot delay after reset.
//   Any target that is not 4-byte aligned is redirected to TRAP_VECTOR, and
//   the PC of the faulting instruction is recorded in epc.
//
// Ports
//   clk           in   system clock, rising-edge state updates
//   rst           in   asynchronous active-low reset
//   stall         in   freeze PC/FSM while running or in trap
//   PCsrc         in   00 seq, 01 branch, 10 jalr, 11 return (epc)
//   ImmOp         in   sign-extended immediate
//   rs1           in   register operand for jalr
//   PC            out  current fetch address
//   PC_plus4      out  PC+4 for link writeback (wraps)
//   fetch_valid   out  PC is a valid fetch this cycle (state RUN)
//   misalign_trap out  one-cycle pulse the cycle after a trap is taken
//   epc           out  PC of the instruction whose target faulted
// ---------------------------------------------------------------------------
module pc_gen_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(32'h0000_0100),
    parameter int                    BOOT_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [1:0]            PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    input  logic [DATA_WIDTH-1:0] rs1,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PC_plus4,
    output logic                  fetch_valid,
    output logic                  misalign_trap,
    output logic [DATA_WIDTH-1:0] epc
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JALR   = 2'b10,
        SRC_RET    = 2'b11
    } src_e;

    // Boot counter is 4 bits wide, enough for BOOT_CYCLES up to 15.
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [3:0]            boot_cnt_q, boot_cnt_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic                  trap_q, trap_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [DATA_WIDTH-1:0] target;
    logic                  target_misaligned;

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);
    assign jalr_sum = rs1 + ImmOp;

    // Next-PC candidate. For jalr, bit 0 is cleared before the alignment
    // check, so an odd jalr sum only traps when bit 1 is set.
    always_comb begin
        target = pc_plus4;
        case (src_e'(PCsrc))
            SRC_SEQ:    target = pc_plus4;
            SRC_BRANCH: target = pc_q + ImmOp;
            SRC_JALR:   target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
            SRC_RET:    target = epc_q;
            default:    target = pc_plus4;
        endcase
    end

    assign target_misaligned = |target[1:0];

    // Next-state logic: by default every register holds its value, and the
    // trap pulse drops.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        trap_d     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Stall is ignored while booting; PC stays on the reset vector.
                pc_d       = RESET_VECTOR;
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!stall) begin
                    if (target_misaligned) begin
                        epc_d   = pc_q;
                        pc_d    = TRAP_VECTOR;
                        trap_d  = 1'b1;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d = target;
                    end
                end
            end

            ST_TRAP: begin
                // PC already sits on the handler. This is a single dead cycle
                // unless stalled.
                if (!stall) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d    = ST_BOOT;
                boot_cnt_d = '0;
                pc_d       = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            trap_q     <= trap_d;
        end
    end

    assign PC            = pc_q;
    assign PC_plus4      = pc_plus4;
    assign fetch_valid   = (state_q == ST_RUN);
    assign misalign_trap = trap_q;
    assign epc           = epc_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

    localparam int          W   = 32;
    localparam logic [31:0] RV  = 32'h0;
    localparam logic [31:0] TV  = 32'h0000_0100;
    localparam int          BC  = 2;

    logic          clk;
    logic          rst;
    logic          stall;
    logic [1:0]    PCsrc;
    logic [W-1:0]  ImmOp;
    logic [W-1:0]  rs1;
    logic [W-1:0]  PC;
    logic [W-1:0]  PC_plus4;
    logic          fetch_valid;
    logic          misalign_trap;
    logic [W-1:0]  epc;

    pc_gen_unit #(
        .DATA_WIDTH  (W),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR (TV),
        .BOOT_CYCLES (BC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .PCsrc        (PCsrc),
        .ImmOp        (ImmOp),
        .rs1          (rs1),
        .PC           (PC),
        .PC_plus4     (PC_plus4),
        .fetch_valid  (fetch_valid),
        .misalign_trap(misalign_trap),
        .epc          (epc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        v;
        logic        t;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: boot countdown, a trap flag, PC and epc
    int          m_boot_left;
    bit          m_in_trap;
    logic [31:0] m_pc;
    logic [31:0] m_epc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot_left = BC;
        m_in_trap   = 1'b0;
        m_pc        = RV;
        m_epc       = 32'h0;
        exp_q.delete();
    endtask

    // Called at a negedge: drive inputs, predict the state after the next
    // rising edge, queue that prediction, then advance to the next negedge.
    task automatic cyc(input bit st, input logic [1:0] src,
                       input logic [31:0] imm, input logic [31:0] r);
        logic [31:0] tgt;
        bit          pulse;
        exp_t        e;
        stall = st; PCsrc = src; ImmOp = imm; rs1 = r;
        pulse = 1'b0;
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (m_in_trap) begin
            if (!st) m_in_trap = 1'b0;
        end else if (!st) begin
            case (src)
                2'b00:   tgt = m_pc + 32'd4;
                2'b01:   tgt = m_pc + imm;
                2'b10:   begin tgt = r + imm; tgt[0] = 1'b0; end
                default: tgt = m_epc;
            endcase
            if ((tgt % 4) != 0) begin
                m_epc     = m_pc;
                m_pc      = TV;
                m_in_trap = 1'b1;
                pulse     = 1'b1;
            end else begin
                m_pc = tgt;
            end
        end
        e.pc  = m_pc;
        e.epc = m_epc;
        e.v   = (m_boot_left == 0) && !m_in_trap;
        e.t   = pulse;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: pops one prediction per rising edge and compares it with the DUT.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",       PC,                     e.pc);
                chk("pc_plus4", PC_plus4,               e.pc + 32'd4);
                chk("epc",      epc,                    e.epc);
                chk("valid",    {31'b0, fetch_valid},   {31'b0, e.v});
                chk("trap",     {31'b0, misalign_trap}, {31'b0, e.t});
            end
        end
    end

    initial begin
        rst = 1'b0; stall = 1'b0; PCsrc = 2'b00; ImmOp = '0; rs1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pc",    PC,                   RV);
        chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_epc",   epc,                  32'd0);
        rst = 1'b1;

        // Boot: two invalid cycles, then fetch at 0, then seq to 0x10
        cyc(1, 2'b01, 32'h3, 0);
        chk("boot1_valid", {31'b0, fetch_valid}, 32'd0);
        cyc(0, 2'b00, 0, 0);
        chk("boot_first_valid", {31'b0, fetch_valid}, 32'd1);
        chk("boot_first_pc", PC, 32'h0);
        cyc(0, 2'b00, 0, 0);
        chk("seq4", PC, 32'h4);
        cyc(0, 2'b00, 0, 0);
        chk("seq8", PC, 32'h8);
        cyc(0, 2'b00, 0, 0);
        cyc(0, 2'b00, 0, 0);
        chk("at10", PC, 32'h10);

        // Branch back by 8, stall, release
        cyc(0, 2'b01, 32'hFFFF_FFF8, 0);
        chk("branch_m8", PC, 32'h8);
        repeat (3) cyc(1, 2'b00, 0, 0);
        chk("stall_hold", PC, 32'h8);
        cyc(0, 2'b00, 0, 0);
        chk("stall_release", PC, 32'hC);

        // JALR bit-0 clear
        cyc(0, 2'b10, 32'h3, 32'h201);
        chk("jalr_pc", PC, 32'h204);
        chk("jalr_notrap", {31'b0, misalign_trap}, 32'd0);

        // Misaligned branch from 0x20, handler, return
        cyc(0, 2'b10, 32'h0, 32'h20);
        cyc(0, 2'b01, 32'h6, 0);
        chk("trap_pulse", {31'b0, misalign_trap}, 32'd1);
        chk("trap_epc",   epc, 32'h20);
        chk("trap_pc",    PC,  TV);
        chk("trap_valid", {31'b0, fetch_valid}, 32'd0);
        cyc(0, 2'b00, 0, 0);
        chk("handler_pc",    PC, TV);
        chk("handler_valid", {31'b0, fetch_valid}, 32'd1);
        chk("handler_pulse", {31'b0, misalign_trap}, 32'd0);
        cyc(0, 2'b00, 0, 0);
        cyc(0, 2'b11, 0, 0);
        chk("return_pc", PC, 32'h20);

        // Wrap and stalled fault
        cyc(0, 2'b10, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_plus4", PC_plus4, 32'h0);
        cyc(0, 2'b00, 0, 0);
        chk("wrap_pc",  PC,       32'h0);
        chk("wrap_pc4", PC_plus4, 32'h4);
        cyc(1, 2'b01, 32'h2, 0);
        chk("stalled_fault_pc",   PC, 32'h0);
        chk("stalled_fault_trap", {31'b0, misalign_trap}, 32'd0);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            imm = $urandom();
            if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            cyc($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), imm, $urandom());
        end

        // Async reset mid-trap (pulse still high), between clock edges
        cyc(0, 2'b10, 32'h0, 32'h40);
        cyc(0, 2'b01, 32'h2, 0);
        chk("pre_rst_trap", {31'b0, misalign_trap}, 32'd1);
        stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("async_pc",    PC,                     RV);
        chk("async_epc",   epc,                    32'd0);
        chk("async_trap",  {31'b0, misalign_trap}, 32'd0);
        chk("async_valid", {31'b0, fetch_valid},   32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Re-boot, then more random traffic
        for (int i = 0; i < 200; i++) begin
            logic [31:0] imm;
            imm = $urandom();
            if ($urandom_range(0, 2) != 0) imm[1:0] = 2'b00;
            cyc($urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), imm, $urandom());
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised successor to the single-cycle PC register/top.
- Generates the fetch PC for the CPU core. Supports:
  - sequential, branch, JALR and return-from-trap next-PC modes;
  - a pipeline stall;
  - a configurable boot delay;
  - misaligned-target detection, which redirects to a trap vector and records the faulting PC.
- Sits between the control unit / ALU and instruction memory.

Parameters:
- DATA_WIDTH, 32, width of PC, immediate, rs1 and all address outputs.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target trap.
- BOOT_CYCLES, 2, cycles after reset release before the first valid fetch (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  1 = freeze PC and FSM (RUN/TRAP only).
- PCsrc  in  2  next-PC select: 00 seq, 01 branch, 10 jalr, 11 return (epc).
- ImmOp  in  DATA_WIDTH  sign-extended immediate.
- rs1  in  DATA_WIDTH  register operand for jalr.
- PC  out  DATA_WIDTH  current fetch address.
- PC_plus4  out  DATA_WIDTH  PC+4, for link-register writeback.
- fetch_valid  out  1  PC is a valid fetch this cycle.
- misalign_trap  out  1  one-cycle pulse when a trap is taken.
- epc  out  DATA_WIDTH  PC of the instruction whose target faulted.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately):
  - PC=RESET_VECTOR, epc=0, misalign_trap=0, fetch_valid=0;
  - boot counter=0, FSM=BOOT.
- Combinational outputs:
  - PC_plus4 = PC+4, truncated to DATA_WIDTH (wraps modulo 2^DATA_WIDTH).
  - fetch_valid = (state==RUN).
- FSM states: BOOT, RUN, TRAP.
- BOOT:
  - PC held at RESET_VECTOR; counter increments every cycle; stall is ignored.
  - When counter==BOOT_CYCLES-1: go to RUN. The first valid fetch is at RESET_VECTOR, BOOT_CYCLES cycles after rst deasserts.
- RUN, stall=1:
  - PC, epc and state all hold; misalign_trap=0.
  - A misaligned target presented during a stall is not trapped.
- RUN, stall=0: target selected by PCsrc:
  - 00: PC+4.
  - 01: PC+ImmOp.
  - 10: (rs1+ImmOp) with bit0 forced to 0.
  - 11: epc.
  - All adds are modulo 2^DATA_WIDTH; overflow is silently discarded.
- Alignment check, applied after the jalr bit0 clear:
  - Target is legal iff target[1:0]==2'b00.
  - Legal target: PC<=target next edge.
  - Illegal target: epc<=PC (current), PC<=TRAP_VECTOR, misalign_trap=1 for exactly the following cycle, state<=TRAP.
- TRAP:
  - fetch_valid=0; PC already equals TRAP_VECTOR.
  - If stall=0: go to RUN next cycle; the first handler fetch is one cycle after the trap pulse.
  - If stall=1: stay in TRAP.
  - misalign_trap deasserts after one cycle regardless of stall.
- Return (PCsrc=11):
  - PC<=epc. epc is by construction 4-aligned, so this is never trapped.
  - epc is unchanged by the return.
- A second trap overwrites epc; there is no nesting.
- Sequential mode can never fault while PC stays aligned. If a misaligned RESET_VECTOR is configured, the first seq fetch traps.
- rst asserted in any state, including mid-TRAP or mid-stall: immediate return to the reset values above.

Test Plan:
- Reset/boot: BOOT_CYCLES=2, release rst at t0.
  - PC=0 and fetch_valid=0 for 2 cycles, then fetch_valid=1 at PC=0.
  - Seq advances 0→4→8; PC_plus4 tracks PC+4.
- Branch and stall:
  - At PC=0x10, PCsrc=01, ImmOp=-8 → PC=0x08.
  - Then stall=1 for 3 cycles with PCsrc=00 → PC stays 0x08.
  - Release stall → PC=0x0C.
- JALR bit clear: rs1=0x201, ImmOp=0x3, PCsrc=10 → PC=0x204, no trap.
- Misalign trap and return:
  - At PC=0x20, PCsrc=01, ImmOp=0x6 → misalign_trap=1 for one cycle, epc=0x20, PC=0x100, fetch_valid=0 for one cycle.
  - Then handler fetch at 0x100.
  - Later PCsrc=11 → PC=0x20.
- Wrap and stalled fault:
  - PC=0xFFFF_FFFC, PCsrc=00 → PC=0x0, PC_plus4=0x4.
  - Misaligned branch with stall=1 → no trap, PC unchanged.
- Async reset mid-trap: assert rst between clock edges during TRAP.
  - PC=0, epc=0, misalign_trap=0 immediately, without waiting for a clock edge.
  - FSM restarts in BOOT.
